// File: rtl/io_uart.sv
// rtl/io_uart.sv - CPU IO-mapped 8N1 UART (DATA 0x1000, STATUS 0x1001) with TX FIFO
// Optional 4-entry RX FIFO when IO_UART_RX_FIFO_EN is defined; otherwise a single holding register.
module io_uart #(
    parameter int DIVISOR = 217,
    parameter int TXDEPTH = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam int TPW = $clog2(TXDEPTH);
    localparam logic [15:0] DIV_RELOAD  = 16'(DIVISOR - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(DIVISOR / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic sel_data, sel_stat, rd_data, rd_stat;
    assign sel_data = (io_addr == 16'h1000);
    assign sel_stat = (io_addr == 16'h1001);
    assign rd_data  = io_rd && sel_data;
    assign rd_stat  = io_rd && sel_stat;

    logic unused_ok;
    assign unused_ok = ^io_wdata[15:8];

    // TX FIFO
    logic [7:0]     tx_mem [TXDEPTH];
    logic [TPW-1:0] tx_wp, tx_rp;
    logic [TPW:0]   tx_cnt;
    logic           tx_full, tx_empty, tx_push, tx_pop, tx_idle, tx_tick;
    state_t         tx_state, tx_next;
    logic [15:0]    tx_div;
    logic [2:0]     tx_bit;
    logic [7:0]     tx_shift;

    assign tx_full  = (tx_cnt == (TPW+1)'(TXDEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign tx_push  = io_wr && sel_data && !tx_full;
    assign tx_tick  = (tx_div == 16'd0);
    assign tx_idle  = tx_empty && (tx_state == S_IDLE);

    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin
                         tx_pop  = 1'b1;
                         tx_next = S_START;
                     end
            S_START: if (tx_tick) tx_next = S_DATA;
            S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = S_STOP;
            S_STOP:  if (tx_tick) begin
                         if (!tx_empty) begin
                             tx_pop  = 1'b1;
                             tx_next = S_START;
                         end else begin
                             tx_next = S_IDLE;
                         end
                     end
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= io_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= S_IDLE;
            tx_div   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'd0;
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_cnt   <= '0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_shift <= tx_mem[tx_rp];
                tx_rp    <= tx_rp + 1'b1;
                tx_div   <= DIV_RELOAD;
                tx_bit   <= 3'd0;
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_div <= DIV_RELOAD;
                    if (tx_state == S_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_div <= tx_div - 16'd1;
                end
            end
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            tx_cnt <= tx_cnt + (TPW+1)'(tx_push) - (TPW+1)'(tx_pop);
        end
    end

    assign uart_tx = (tx_state == S_START) ? 1'b0 :
                     (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

    // RX: two-flop synchroniser plus one more flop for falling-edge detection
    logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, rx_deliver, rx_ferr;
    state_t      rx_state, rx_next;
    logic [15:0] rx_div;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_tick = (rx_div == 16'd0);

    always_comb begin
        rx_next    = rx_state;
        rx_deliver = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: if (rx_tick) rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = S_STOP;
            S_STOP:  if (rx_tick) begin
                         rx_next    = S_IDLE;
                         rx_deliver = rx_s2;
                         rx_ferr    = !rx_s2;
                     end
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_div   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'd0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            // Idle keeps the half-bit reload armed so START samples mid-bit
            if (rx_state == S_IDLE) begin
                rx_div <= HALF_RELOAD;
                rx_bit <= 3'd0;
            end else if (rx_tick) begin
                rx_div <= DIV_RELOAD;
                if (rx_state == S_DATA) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 3'd1;
                end
            end else begin
                rx_div <= rx_div - 16'd1;
            end
        end
    end

    // RX storage; a DATA read in the delivery cycle frees space first
    logic       rx_valid, rx_take, rx_accept;
    logic [7:0] rx_head;
`ifdef IO_UART_RX_FIFO_EN
    logic [7:0] rx_mem [4];
    logic [1:0] rx_wp, rx_rp;
    logic [2:0] rx_cnt;

    assign rx_valid  = (rx_cnt != 3'd0);
    assign rx_head   = rx_mem[rx_rp];
    assign rx_take   = rd_data && rx_valid;
    assign rx_accept = rx_deliver && ((rx_cnt != 3'd4) || rx_take);

    always_ff @(posedge clk) begin
        if (rx_accept) rx_mem[rx_wp] <= rx_shift;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_wp  <= 2'd0;
            rx_rp  <= 2'd0;
            rx_cnt <= 3'd0;
        end else begin
            if (rx_accept) rx_wp <= rx_wp + 2'd1;
            if (rx_take)   rx_rp <= rx_rp + 2'd1;
            rx_cnt <= rx_cnt + 3'(rx_accept) - 3'(rx_take);
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_full;

    assign rx_valid  = rx_full;
    assign rx_head   = rx_hold;
    assign rx_take   = rd_data && rx_full;
    assign rx_accept = rx_deliver && (!rx_full || rx_take);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_hold <= 8'd0;
            rx_full <= 1'b0;
        end else if (rx_accept) begin
            rx_hold <= rx_shift;
            rx_full <= 1'b1;
        end else if (rx_take) begin
            rx_full <= 1'b0;
        end
    end
`endif

    logic rx_overrun, rx_frame_err;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_deliver && !rx_accept) rx_overrun <= 1'b1;
            else if (rd_stat)             rx_overrun <= 1'b0;
            if (rx_ferr)                  rx_frame_err <= 1'b1;
            else if (rd_stat)             rx_frame_err <= 1'b0;
        end
    end

    always_comb begin
        io_din = 16'h0000;
        if (io_rd) begin
            if (sel_data)
                io_din = {8'h00, rx_valid ? rx_head : 8'h00};
            else if (sel_stat)
                io_din = {11'd0, rx_frame_err, rx_overrun, rx_valid, tx_idle, tx_full};
        end
    end
endmodule

// File: doc/io_uart.md
IO_UART -- requirements
Module: io_uart

Interface
REQ-001 SHALL have parameter DIVISOR, default 217, giving clk cycles per UART bit period (legal range 4..65535).
REQ-002 SHALL have parameter TXDEPTH, default 4, giving TX FIFO depth (power of 2, minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetq  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port io_rd  input  1  CPU IO read strobe, one cycle per read.
REQ-006 SHALL have port io_wr  input  1  CPU IO write strobe, one cycle per write.
REQ-007 SHALL have port io_addr  input  16  IO address (CPU st0).
REQ-008 SHALL have port io_wdata  input  16  IO write data (CPU st1).
REQ-009 SHALL have port io_din  output  16  read data to CPU, combinational, valid in the same cycle as io_rd.
REQ-010 SHALL have port uart_rx  input  1  serial receive line, asynchronous to clk.
REQ-011 SHALL have port uart_tx  output  1  serial transmit line, idle high.

Function
REQ-012 SHALL use this register map: 0x1000 DATA; 0x1001 STATUS; any other address reads 0x0000, and writes to it are ignored.
REQ-013 SHALL, on io_wr to DATA, push io_wdata[7:0] into the TX FIFO; if the FIFO is full, the write is dropped and state is unchanged.
REQ-014 SHALL, on io_rd of DATA, return {8'h00, rx_byte}, and SHALL consume that byte at the clock edge ending the read cycle; if no byte is held, it returns 0x0000 and has no effect.
REQ-015 SHALL return STATUS as follows: bit0 tx_full; bit1 tx_idle (FIFO empty and shifter idle); bit2 rx_valid; bit3 rx_overrun; bit4 rx_frame_err; bits 15:5 = 0.
REQ-016 SHALL clear bit3 and bit4 at the edge ending an io_rd of STATUS; a flag set in that same cycle wins, so the flag remains set.
REQ-017 SHALL drive io_din to 0x0000 whenever io_rd is low.
REQ-018 SHALL implement the TX shifter as a state machine with states IDLE, START, DATA, STOP; each state holds for DIVISOR cycles per bit; output is 8N1, LSB first.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop the FIFO and enter START on the next edge, with uart_tx=0 from that edge.
REQ-020 SHALL, after STOP, enter START directly (no idle gap) if the FIFO is non-empty, otherwise enter IDLE.
REQ-021 SHALL, on a same-cycle FIFO push and shifter pop, perform both; the count is unchanged, and the full condition is evaluated before the pop.
REQ-022 SHALL synchronise uart_rx through 2 flops before any use.
REQ-023 SHALL implement the RX state machine as IDLE, START, DATA, STOP: a synchronised falling edge enters START; the bit is sampled at DIVISOR/2 (integer division); if the sample is high, return to IDLE (glitch rejected); data bits are sampled at DIVISOR intervals thereafter.
REQ-024 SHALL, when the stop-bit sample is high, deliver the byte to RX storage; when it is low, discard the byte and set rx_frame_err.
REQ-025 SHALL, when a delivered byte finds RX storage full, discard the new byte and set rx_overrun; stored bytes are kept.
REQ-026 SHALL, when a byte delivery and a DATA read occur in the same cycle, perform the read first, so the new byte is accepted without overrun.
REQ-027 SHALL make the bit-period counters wrap only by reload to DIVISOR-1; no counter may overflow.

Reset
REQ-028 SHALL, on resetq low, immediately set uart_tx=1, both state machines to IDLE, TX FIFO and RX storage empty, and all flags 0; io_din then reads 0x0000.
REQ-029 SHALL abort any frame in progress when reset is asserted mid-frame; after release, TX stays idle until a new write, and RX waits for a fresh falling edge.

Configuration
REQ-030 SHALL, with macro IO_UART_RX_FIFO_EN defined, hold received bytes in a 4-entry RX FIFO; rx_valid means non-empty; overrun means a delivery to a full FIFO; DATA returns the oldest byte.
REQ-031 SHALL, without IO_UART_RX_FIFO_EN, hold received bytes in a single holding register; rx_valid means the register is full; overrun means a delivery while the register is full.

Verification (DIVISOR=4 for all scenarios)
REQ-032 SHALL verify TX of one byte: write 0x1000=0x00A5 -> uart_tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; STATUS bit1=1 after 40 cycles.
REQ-033 SHALL verify TX overflow: 6 back-to-back writes 0x01..0x06 with TXDEPTH=4 -> 0x01..0x05 transmitted, 0x06 dropped; STATUS bit0=1 while the FIFO holds 4 bytes.
REQ-034 SHALL verify RX: drive the frame for 0x3C -> STATUS reads 0x0006 (tx_idle, rx_valid); DATA reads 0x003C; STATUS then reads 0x0002.
REQ-035 SHALL verify framing error and glitch rejection: a frame with stop=0 -> bit4 set, rx_valid=0, and bit4 cleared after a STATUS read; a 1-cycle low glitch -> no byte received.
REQ-036 SHALL verify overrun: 2 frames without FIFO (5 with FIFO) and no reads -> bit3=1, and DATA returns the first byte.
REQ-037 SHALL verify reset mid-TX: assert resetq low during DATA -> uart_tx=1 asynchronously and STATUS=0x0002 after release.
